// File: rtl/uart_line_rx.sv
// uart_line_rx: buffers one LF-terminated line (CR dropped) and replays it as a valid/ready stream with a last marker.
// Optional idle timeout for partial lines is enabled by defining UART_LINE_TIMEOUT_EN.
module uart_line_rx #(
  parameter int MAX_LEN    = 32,
  parameter int CLK_FRE    = 27,
  parameter int TIMEOUT_MS = 10,
  localparam int LW        = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [LW-1:0] line_len,
  output logic          line_done,
  output logic          overflow,
  output logic          timeout
);
  localparam int AW = $clog2(MAX_LEN);
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DELIVER = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [LW-1:0] wr_cnt_q, wr_cnt_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          ovfp_q, ovfp_d;
  logic [7:0]    buf_q [MAX_LEN];
  logic          acc, xfer, is_cr, is_lf, has_data, we, to_fire;
  assign in_ready  = state_q == COLLECT;
  assign out_valid = state_q == DELIVER;
  assign out_data  = buf_q[rd_ptr_q[AW-1:0]];
  assign out_last  = out_valid && (rd_ptr_q == len_q - LW'(1));
  assign line_len  = len_q;
  assign line_done = done_q;
  assign overflow  = ovfp_q;
  assign acc       = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign is_cr     = in_data == 8'h0D;
  assign is_lf     = in_data == 8'h0A;
  assign has_data  = (wr_cnt_q != '0) || ovf_q;
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    ovfp_d   = 1'b0;
    we       = 1'b0;
    if (acc && is_lf && has_data) begin
      len_d    = wr_cnt_q;
      done_d   = 1'b1;
      ovfp_d   = ovf_q;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      state_d  = DELIVER;
    end else if (acc && !is_lf && !is_cr) begin
      we       = wr_cnt_q != LW'(MAX_LEN);
      wr_cnt_d = we ? wr_cnt_q + LW'(1) : wr_cnt_q;
      ovf_d    = ovf_q || !we;
    end else if (to_fire) begin
      wr_cnt_d = '0;
      ovf_d    = 1'b0;
    end else if (xfer) begin
      rd_ptr_d = out_last ? '0 : rd_ptr_q + LW'(1);
      wr_cnt_d = out_last ? '0 : wr_cnt_q;
      state_d  = out_last ? COLLECT : DELIVER;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      ovfp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      ovfp_q   <= ovfp_d;
    end
  end
  // line storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (we) buf_q[wr_cnt_q[AW-1:0]] <= in_data;
  end
`ifdef UART_LINE_TIMEOUT_EN
  localparam logic [31:0] TO_LIM = 32'(CLK_FRE * 1000 * TIMEOUT_MS - 1);
  logic [31:0] idle_q, idle_d;
  logic        to_q, to_d;
  assign to_fire = in_ready && has_data && !acc && (idle_q == TO_LIM);
  assign to_d    = to_fire;
  assign idle_d  = (!in_ready || acc || !has_data || to_fire) ? '0 : idle_q + 32'd1;
  assign timeout = to_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
      to_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      to_q   <= to_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(CLK_FRE), 32'(TIMEOUT_MS)};
  assign to_fire    = 1'b0;
  assign timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_uart_line_rx.sv
// tb_uart_line_rx: table-driven directed checks for uart_line_rx plus hand-written overflow, reset and timeout sequences.
module tb_uart_line_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_last, line_done, overflow, timeout;
  logic [7:0] out_data;
  logic [5:0] line_len;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_dat;
    logic       e_last;
    logic       e_done;
    logic       e_ovf;
    logic [5:0] e_len;
  } vec_t;
  vec_t tv[$];

  uart_line_rx #(.MAX_LEN(32), .CLK_FRE(1), .TIMEOUT_MS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .line_len(line_len), .line_done(line_done), .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic rdy, input logic e_ir, input logic e_ov,
                     input logic [7:0] e_dat, input logic e_last, input logic e_done, input logic e_ovf,
                     input logic [5:0] e_len);
    vec_t r;
    r = '{v, d, rdy, e_ir, e_ov, e_dat, e_last, e_done, e_ovf, e_len};
    tv.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    in_valid = v;
    in_data = d;
    out_ready = r;
    #1;
  endtask

  task automatic expect_out(input logic e_ir, input logic e_ov, input logic [7:0] e_dat, input logic e_last,
                            input logic e_done, input logic e_ovf, input logic [5:0] e_len);
    chk("in_ready", 32'(in_ready), 32'(e_ir));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("out_last", 32'(out_last), 32'(e_last));
    chk("line_done", 32'(line_done), 32'(e_done));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    chk("line_len", 32'(line_len), 32'(e_len));
    chk("timeout", 32'(timeout), 32'd0);
    if (e_ov) chk("out_data", 32'(out_data), 32'(e_dat));
  endtask

  initial begin
    // "AB\r\n" streamed straight out
    add(1, 8'h41, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h42, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h0D, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h0A, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 8'h41, 0, 1, 0, 2);
    add(0, 8'h00, 1, 0, 1, 8'h42, 1, 0, 0, 2);
    add(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0, 2);
    // "\r\n\n" produces nothing
    add(1, 8'h0D, 1, 1, 0, 8'h00, 0, 0, 0, 2);
    add(1, 8'h0A, 1, 1, 0, 8'h00, 0, 0, 0, 2);
    add(1, 8'h0A, 1, 1, 0, 8'h00, 0, 0, 0, 2);
    add(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0, 2);
    // "XYZ\n" with out_ready 1,0,0,1,0,1; a byte offered mid-delivery is lost
    add(1, 8'h58, 0, 1, 0, 8'h00, 0, 0, 0, 2);
    add(1, 8'h59, 0, 1, 0, 8'h00, 0, 0, 0, 2);
    add(1, 8'h5A, 0, 1, 0, 8'h00, 0, 0, 0, 2);
    add(1, 8'h0A, 0, 1, 0, 8'h00, 0, 0, 0, 2);
    add(0, 8'h00, 1, 0, 1, 8'h58, 0, 1, 0, 3);
    add(1, 8'h55, 0, 0, 1, 8'h59, 0, 0, 0, 3);
    add(0, 8'h00, 0, 0, 1, 8'h59, 0, 0, 0, 3);
    add(0, 8'h00, 1, 0, 1, 8'h59, 0, 0, 0, 3);
    add(0, 8'h00, 0, 0, 1, 8'h5A, 1, 0, 0, 3);
    add(0, 8'h00, 1, 0, 1, 8'h5A, 1, 0, 0, 3);
    add(1, 8'h0A, 0, 1, 0, 8'h00, 0, 0, 0, 3);
    add(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 3);

    #1;
    expect_out(1, 0, 8'h00, 0, 0, 0, 0);
    drive(0, 8'h00, 0);
    drive(0, 8'h00, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].v, tv[i].d, tv[i].rdy);
      expect_out(tv[i].e_ir, tv[i].e_ov, tv[i].e_dat, tv[i].e_last, tv[i].e_done, tv[i].e_ovf, tv[i].e_len);
    end

    // 40 bytes into a 32-byte buffer
    for (int i = 0; i < 40; i++) begin
      drive(1, 8'(8'h30 + i), 1);
      expect_out(1, 0, 8'h00, 0, 0, 0, 3);
    end
    drive(1, 8'h0A, 1);
    expect_out(1, 0, 8'h00, 0, 0, 0, 3);
    for (int i = 0; i < 32; i++) begin
      drive(0, 8'h00, 1);
      expect_out(0, 1, 8'(8'h30 + i), i == 31, i == 0, i == 0, 32);
    end
    drive(0, 8'h00, 1);
    expect_out(1, 0, 8'h00, 0, 0, 0, 32);

    // reset after one of three bytes delivered
    drive(1, 8'h4D, 0);
    drive(1, 8'h4E, 0);
    drive(1, 8'h4F, 0);
    drive(1, 8'h0A, 0);
    expect_out(1, 0, 8'h00, 0, 0, 0, 32);
    drive(0, 8'h00, 1);
    expect_out(0, 1, 8'h4D, 0, 1, 0, 3);
    drive(0, 8'h00, 0);
    expect_out(0, 1, 8'h4E, 0, 0, 0, 3);
    rst_n = 1'b0;
    #1;
    expect_out(1, 0, 8'h00, 0, 0, 0, 0);
    drive(0, 8'h00, 0);
    drive(0, 8'h00, 0);
    rst_n = 1'b1;
    drive(1, 8'h51, 1);
    expect_out(1, 0, 8'h00, 0, 0, 0, 0);
    drive(1, 8'h0A, 1);
    expect_out(1, 0, 8'h00, 0, 0, 0, 0);
    drive(0, 8'h00, 1);
    expect_out(0, 1, 8'h51, 1, 1, 0, 1);
    drive(0, 8'h00, 1);
    expect_out(1, 0, 8'h00, 0, 0, 0, 1);

`ifdef UART_LINE_TIMEOUT_EN
    begin
      int n;
      logic seen, done_seen;
      n = 0;
      seen = 1'b0;
      done_seen = 1'b0;
      drive(1, 8'h41, 1);
      drive(1, 8'h42, 1);
      while (!seen && n < 1100) begin
        drive(0, 8'h00, 1);
        n++;
        seen = timeout;
        done_seen = done_seen || line_done || out_valid;
      end
      chk("timeout_seen", 32'(seen), 32'd1);
      chk("timeout_cycle", 32'(n), 32'd1001);
      chk("timeout_no_line", 32'(done_seen), 32'd0);
      drive(0, 8'h00, 1);
      chk("timeout_pulse_width", 32'(timeout), 32'd0);
      drive(1, 8'h43, 1);
      drive(1, 8'h0A, 1);
      drive(0, 8'h00, 1);
      expect_out(0, 1, 8'h43, 1, 1, 0, 1);
      drive(0, 8'h00, 1);
      expect_out(1, 0, 8'h00, 0, 0, 0, 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_line_rx.md
Name: uart_line_rx

Overview:
Line assembler on the receive side of the board UART link. It consumes the byte stream from the uart_rx byte interface (valid/ready) and buffers one text line terminated by LF, discarding CR. It then replays the completed line as a byte stream with a last marker, for command parsers or loopback logic. It is the receive-side counterpart of the fixed-string/echo sender in the UART test top.

Parameters:
MAX_LEN, 32, line buffer depth in bytes; must be >=2. Bytes beyond this are dropped.
CLK_FRE, 27, clock frequency in MHz. Used only by the timeout option.
TIMEOUT_MS, 10, partial-line idle timeout in ms. Used only by the timeout option.
LW (localparam), $clog2(MAX_LEN+1), width of line_len.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_data  input  8  received byte from uart_rx
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a byte
out_data  output  8  line byte at current read pointer
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_last  output  1  out_data is the final byte of the line
line_len  output  LW  stored byte count of the current/last line
line_done  output  1  one-cycle pulse: line terminated, delivery starts next cycle
overflow  output  1  one-cycle pulse coincident with line_done if bytes were dropped
timeout  output  1  one-cycle pulse: partial line discarded; tied 0 without the option

Behaviour:
- Reset values: state=COLLECT, wr_cnt=0, rd_ptr=0, ovf_flag=0, line_len=0; in_ready=1, out_valid=0, out_last=0, line_done=0, overflow=0, timeout=0. out_data is don't-care while out_valid=0.
- Buffer: MAX_LEN x 8 register array. Written only in COLLECT, read only in DELIVER. Contents are not cleared by reset.
- A transfer occurs when valid&&ready is high on a rising clk edge.
- State COLLECT: in_ready=1, out_valid=0. On each accepted byte:
  - 0x0D: discarded, no state change.
  - 0x0A with wr_cnt==0 and ovf_flag==0: empty line, discarded, no pulse.
  - 0x0A otherwise: line_len<=wr_cnt; line_done=1 next cycle; overflow=ovf_flag next cycle; rd_ptr<=0; ovf_flag<=0; go DELIVER.
  - Any other byte with wr_cnt<MAX_LEN: buf[wr_cnt]<=byte; wr_cnt++.
  - Any other byte with wr_cnt==MAX_LEN: byte dropped; ovf_flag<=1.
- Overflow with zero stored bytes cannot occur because MAX_LEN>=1.
- State DELIVER:
  - in_ready=0. Upstream bytes arriving now are lost; the upstream uart_rx has no backpressure, by design.
  - out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==line_len-1).
  - On out transfer with out_last=0: rd_ptr++.
  - On out transfer with out_last=1: wr_cnt<=0, rd_ptr<=0, go COLLECT. out_valid drops and in_ready rises on the next cycle.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
- Latency: LF accepted at edge N -> line_done=1, out_valid=1, first byte presented during cycle N+1. A line of L bytes with out_ready held at 1 takes L cycles to deliver. The next byte is accepted no earlier than 1 cycle after the last out transfer.
- line_len holds its value until the next line terminates.
- Reset mid-line or mid-delivery: the partial or pending line is abandoned and all outputs return to reset values immediately (async).

Optional Feature:
- Macro: UART_LINE_TIMEOUT_EN.
- Defined:
  - 32-bit idle counter increments each cycle in COLLECT while (wr_cnt!=0 || ovf_flag). It clears on any accepted byte and whenever the block is not in COLLECT.
  - When the counter reaches CLK_FRE*1000*TIMEOUT_MS-1: wr_cnt<=0, ovf_flag<=0, counter<=0, timeout=1 for one cycle. No line_done.
  - An accepted byte in the same cycle as the timeout condition wins: the byte is processed and the counter clears.
- Undefined: no counter logic; timeout port tied 0; a partial line waits indefinitely.

Test Plan:
- Send "AB\r\n" (0x41,0x42,0x0D,0x0A), out_ready=1 -> line_done 1 cycle after LF. line_len=2. out stream 0x41 (last=0), then 0x42 (last=1), in consecutive cycles. overflow=0. in_ready returns to 1 on the next cycle.
- Send "\r\n\n" alone -> no line_done, no out_valid, in_ready stays 1.
- MAX_LEN=32: send 40 bytes 0x30..0x57 then LF -> line_len=32; line_done and overflow pulse together; 32 bytes 0x30..0x4F delivered, last on 0x4F.
- Deliver "XYZ\n" with out_ready toggling 1,0,0,1,0,1 -> data and last held stable while stalled. Exactly 3 transfers X,Y,Z occur.
- Assert rst_n=0 mid-delivery after 1 of 3 bytes -> out_valid=0 and in_ready=1 immediately. Next "Q\n" delivers only 0x51 with line_len=1.
- With UART_LINE_TIMEOUT_EN, CLK_FRE=1, TIMEOUT_MS=1: send "AB", idle 1000 cycles -> timeout pulse, no line_done. Then "C\n" delivers only 0x43.
